// File: rtl/roll_pkg.sv
// Shared types and die lookup tables for the roll scheduler.
// Die codes 0..5 select d4..d20; every other code is rejected before the TRNG is touched.
package roll_pkg;

    localparam logic [3:0] DIE_D4  = 4'd0;
    localparam logic [3:0] DIE_D6  = 4'd1;
    localparam logic [3:0] DIE_D8  = 4'd2;
    localparam logic [3:0] DIE_D10 = 4'd3;
    localparam logic [3:0] DIE_D12 = 4'd4;
    localparam logic [3:0] DIE_D20 = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_BAD_DIE = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_RETRY   = 2'b11
    } err_t;

    function automatic logic die_valid(input logic [3:0] code);
        return code <= DIE_D20;
    endfunction

    function automatic logic [4:0] die_sides(input logic [3:0] code);
        case (code)
            DIE_D4:  return 5'd4;
            DIE_D6:  return 5'd6;
            DIE_D8:  return 5'd8;
            DIE_D10: return 5'd10;
            DIE_D12: return 5'd12;
            DIE_D20: return 5'd20;
            default: return 5'd0;
        endcase
    endfunction

    // Largest multiple of the side count that fits in 0..127; samples at or above it are redrawn.
    function automatic logic [7:0] die_limit(input logic [3:0] code);
        case (code)
            DIE_D4:  return 8'd128;
            DIE_D6:  return 8'd126;
            DIE_D8:  return 8'd128;
            DIE_D10: return 8'd120;
            DIE_D12: return 8'd120;
            DIE_D20: return 8'd120;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/roll_reduce.sv
// Combinational reduction of one 7-bit TRNG sample to an unbiased die roll.
// accept is low for invalid die codes and for samples in the biased tail.
module roll_reduce
    import roll_pkg::*;
(
    input  logic [3:0] die,
    input  logic [6:0] sample,
    output logic       accept,
    output logic [4:0] roll
);

    logic [4:0] rem;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        accept = 1'b0;
        rem    = '0;
        roll   = '0;
        if (die_valid(die)) begin
            accept = {1'b0, sample} < die_limit(die);
            rem    = 5'(sample % {2'b00, die_sides(die)});
            roll   = rem + 5'd1;
        end
    end

endmodule

// File: rtl/roll_scheduler.sv
// Round-robin arbiter and sequencer sharing one TRNG among N_REQ roll requesters.
// One roll is in flight at a time; results leave through a valid/ready port.
module roll_scheduler
    import roll_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [4*N_REQ-1:0]       i_die_sel,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_stop,
    input  logic                     i_valid,
    input  logic [6:0]               i_random_data,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [$clog2(N_REQ)-1:0] o_res_id,
    output logic [4:0]               o_res_roll,
    output logic [1:0]               o_res_err,
    output logic                     o_busy
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [3:0]         cur_die;
    logic [6:0]         sample;
    logic [TIMER_W-1:0] timer;
    logic [RETRY_W-1:0] retry;
    logic [ID_W-1:0]    res_id;
    logic [4:0]         res_roll;
    err_t               res_err;

    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic [3:0]         pick_die;
    logic               accept;
    logic [4:0]         roll;
    logic [ID_W-1:0]    next_rr;

    // Lower segment first, upper segment (at/after rr_ptr) overrides; descending loops keep the lowest index.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (i_req[j] && (j < int'(rr_ptr))) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(j);
            end
        end
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (i_req[j] && (j >= int'(rr_ptr))) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(j);
            end
        end
    end

    always_comb begin
        pick_die = '0;
        o_grant  = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (pick_id == ID_W'(j)) begin
                pick_die = i_die_sel[4*j +: 4];
            end
        end
        if (state == ST_IDLE && pick_found) begin
            o_grant[pick_id] = 1'b1;
        end
    end

    assign next_rr = (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);

    roll_reduce u_reduce (
        .die    (cur_die),
        .sample (sample),
        .accept (accept),
        .roll   (roll)
    );

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            cur_id   <= '0;
            cur_die  <= '0;
            sample   <= '0;
            timer    <= '0;
            retry    <= '0;
            res_id   <= '0;
            res_roll <= '0;
            res_err  <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        cur_id  <= pick_id;
                        cur_die <= pick_die;
                        if (!die_valid(pick_die)) begin
                            res_id   <= pick_id;
                            res_roll <= '0;
                            res_err  <= ERR_BAD_DIE;
                            state    <= ST_RESULT;
                        end else begin
                            timer <= '0;
                            retry <= '0;
                            state <= ST_SAMPLE;
                        end
                    end
                end
                ST_SAMPLE: begin
                    timer <= timer + TIMER_W'(1);
                    if (i_valid) begin
                        sample <= i_random_data;
                        state  <= ST_CHECK;
                    end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                        res_id   <= cur_id;
                        res_roll <= '0;
                        res_err  <= ERR_TIMEOUT;
                        state    <= ST_RESULT;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        res_id   <= cur_id;
                        res_roll <= roll;
                        res_err  <= ERR_OK;
                        state    <= ST_RESULT;
                    end else if (retry == RETRY_W'(MAX_RETRY - 1)) begin
                        res_id   <= cur_id;
                        res_roll <= '0;
                        res_err  <= ERR_RETRY;
                        state    <= ST_RESULT;
                    end else begin
                        retry <= retry + RETRY_W'(1);
                        timer <= '0;
                        state <= ST_SAMPLE;
                    end
                end
                ST_RESULT: begin
                    if (i_res_ready) begin
                        rr_ptr <= next_rr;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_stop      = (state != ST_SAMPLE);
    assign o_res_valid = (state == ST_RESULT);
    assign o_busy      = (state != ST_IDLE);
    assign o_res_id    = res_id;
    assign o_res_roll  = res_roll;
    assign o_res_err   = res_err;

endmodule

// File: tb/tb_roll_scheduler.sv
// Directed scoreboard bench for roll_scheduler: expected results are queued at stimulus
// time and popped at each result handshake; cycle-accurate checks cover latency and stop.
module tb_roll_scheduler;

    localparam int N_REQ = 4;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] die_sel;
    logic [3:0]  grant;
    logic        stop;
    logic        valid;
    logic [6:0]  rdata;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [4:0]  res_roll;
    logic [1:0]  res_err;
    logic        busy;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        int id;
        int roll;
        int err;
    } exp_t;

    exp_t sb[$];

    roll_scheduler #(.N_REQ(N_REQ), .TIMEOUT(255), .MAX_RETRY(8)) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_req         (req),
        .i_die_sel     (die_sel),
        .o_grant       (grant),
        .o_stop        (stop),
        .i_valid       (valid),
        .i_random_data (rdata),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_id      (res_id),
        .o_res_roll    (res_roll),
        .o_res_err     (res_err),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Start a new cycle: inputs change 1 time unit after the active edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: limit derived arithmetically rather than from a table.
    function automatic void model(input int code, input int smp, output int roll, output int err);
        int sides;
        case (code)
            0: sides = 4;
            1: sides = 6;
            2: sides = 8;
            3: sides = 10;
            4: sides = 12;
            5: sides = 20;
            default: sides = 0;
        endcase
        if (sides == 0) begin
            roll = 0;
            err  = 1;
        end else if (smp < (128 / sides) * sides) begin
            roll = smp % sides + 1;
            err  = 0;
        end else begin
            roll = 0;
            err  = 3;
        end
    endfunction

    task automatic push(input int id, input int roll, input int err);
        exp_t e;
        e.id   = id;
        e.roll = roll;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic push_model(input int id, input int code, input int smp);
        int r, e;
        model(code, smp, r, e);
        push(id, r, e);
    endtask

    // Called at cycle start; returns at the negedge of the handshake cycle.
    task automatic wait_result(input int budget);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!(res_valid === 1'b1 && res_ready === 1'b1) && n < budget) begin
            cycle();
            @(negedge clk);
            n++;
        end
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(res_valid), 0);
            end else begin
                e = sb.pop_front();
                check("res_id", 32'(res_id), e.id);
                check("res_roll", 32'(res_roll), e.roll);
                check("res_err", 32'(res_err), e.err);
            end
        end else begin
            check("result_missing", 32'(res_valid), 1);
        end
    endtask

    // Called at the start of an IDLE cycle; returns at the start of cycle 1.
    task automatic request(input logic [3:0] mask, input int exp_id, input logic [3:0] code);
        req     = mask;
        die_sel = 16'hFFFF;
        die_sel[4*exp_id +: 4] = code;
        @(negedge clk);
        check("grant", 32'(grant), 32'(4'b0001 << exp_id));
        check("stop_at_grant", 32'(stop), 1);
        cycle();
        req     = '0;
        die_sel = 16'hFFFF;
    endtask

    // One accepted sample at cycle 1; result must appear at cycle 3.
    task automatic do_roll(input logic [3:0] mask, input int exp_id, input logic [3:0] code, input int smp);
        request(mask, exp_id, code);
        valid = 1'b1;
        rdata = 7'(smp);
        push_model(exp_id, int'(code), smp);
        cycle();
        valid = 1'b0;
        wait_result(1);
        cycle();
    endtask

    task automatic do_timeout(input logic [3:0] mask, input int exp_id, input logic [3:0] code,
                              input bit use_valid, input int smp);
        request(mask, exp_id, code);
        if (use_valid) push_model(exp_id, int'(code), smp);
        else           push(exp_id, 0, 2);
        for (int c = 1; c < 255; c++) cycle();
        if (use_valid) begin
            valid = 1'b1;
            rdata = 7'(smp);
        end
        @(negedge clk);
        check("stop_last_sample", 32'(stop), 0);
        cycle();
        valid = 1'b0;
        if (use_valid) begin
            wait_result(1);
        end else begin
            wait_result(0);
            check("stop_after_timeout", 32'(stop), 1);
        end
        cycle();
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = '0;
        die_sel   = 16'hFFFF;
        valid     = 1'b0;
        rdata     = '0;
        res_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stop", 32'(stop), 1);
        check("rst_grant", 32'(grant), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_id", 32'(res_id), 0);
        check("rst_res_roll", 32'(res_roll), 0);
        check("rst_res_err", 32'(res_err), 0);
        check("rst_busy", 32'(busy), 0);
        cycle();
        reset_n = 1'b1;
        cycle();

        // Single request: d6, sample 37 at cycle 4 -> roll 2 at cycle 6
        request(4'b0001, 0, 4'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("stop_sampling", 32'(stop), 0);
            check("busy_sampling", 32'(busy), 1);
            cycle();
        end
        valid = 1'b1;
        rdata = 7'd37;
        push(0, 2, 0);
        @(negedge clk);
        check("stop_cycle4", 32'(stop), 0);
        cycle();
        valid = 1'b0;
        @(negedge clk);
        check("stop_check", 32'(stop), 1);
        check("res_valid_check", 32'(res_valid), 0);
        cycle();
        wait_result(0);
        cycle();
        @(negedge clk);
        check("idle_after_handshake", 32'(busy), 0);
        check("res_valid_idle", 32'(res_valid), 0);
        cycle();

        // Rejection then acceptance on d10
        request(4'b0010, 1, 4'd3);
        valid = 1'b1;
        rdata = 7'd125;
        cycle();
        valid = 1'b0;
        @(negedge clk);
        check("stop_reject_check", 32'(stop), 1);
        check("res_valid_reject", 32'(res_valid), 0);
        cycle();
        valid = 1'b1;
        rdata = 7'd45;
        push(1, 6, 0);
        @(negedge clk);
        check("stop_resample", 32'(stop), 0);
        cycle();
        valid = 1'b0;
        wait_result(1);
        cycle();

        // Eight rejected samples on d20 -> retries exhausted
        request(4'b0100, 2, 4'd5);
        push(2, 0, 3);
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            rdata = 7'd127;
            cycle();
            valid = 1'b0;
            if (i < 7) cycle();
        end
        wait_result(1);
        cycle();

        // d4 accepts the top sample 127
        do_roll(4'b1000, 3, 4'd0, 127);

        // Arbitration with all requests held
        req     = 4'b1111;
        die_sel = 16'h0000;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            check("rr_grant", 32'(grant), 32'(4'b0001 << (g % 4)));
            push_model(g % 4, 0, g * 9 + 1);
            cycle();
            valid = 1'b1;
            rdata = 7'(g * 9 + 1);
            cycle();
            valid = 1'b0;
            wait_result(1);
            cycle();
        end
        req     = '0;
        die_sel = 16'hFFFF;

        // Move rr pointer to 2, then i_req=0011 wraps to id 0
        do_roll(4'b0010, 1, 4'd4, 50);
        do_roll(4'b0011, 0, 4'd2, 77);

        // d10 boundary: 119 is the last accepted sample
        do_roll(4'b0010, 1, 4'd3, 119);

        // Timeout, then i_valid on the final SAMPLE cycle
        do_timeout(4'b0100, 2, 4'd2, 1'b0, 0);
        do_timeout(4'b1000, 3, 4'd2, 1'b1, 10);

        // Bad die code with backpressure; i_valid toggling outside SAMPLE is ignored
        res_ready = 1'b0;
        request(4'b0100, 2, 4'd7);
        push(2, 0, 1);
        valid = 1'b1;
        rdata = 7'd99;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 1);
            check("bp_res_id", 32'(res_id), 2);
            check("bp_res_roll", 32'(res_roll), 0);
            check("bp_res_err", 32'(res_err), 1);
            check("bp_stop", 32'(stop), 1);
            cycle();
        end
        valid     = 1'b0;
        res_ready = 1'b1;
        wait_result(0);
        cycle();
        @(negedge clk);
        check("bp_idle", 32'(busy), 0);
        cycle();

        // Reset during SAMPLE: no result, rr pointer back to 0
        request(4'b0010, 1, 4'd1);
        @(negedge clk);
        cycle();
        cycle();
        reset_n = 1'b0;
        @(negedge clk);
        check("stop_before_reset", 32'(stop), 0);
        cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_stop", 32'(stop), 1);
        check("reset_res_valid", 32'(res_valid), 0);
        check("reset_busy", 32'(busy), 0);
        cycle();
        do_roll(4'b1001, 0, 4'd5, 33);

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
